pwr_cntr_ctrl: RTL and testbench

- Sequencer and arbiter for the shared power-counter memory (memTrans-style, one 32-bit word per library cell).
- Collects toggle events from the NOT, NAND, NOR, MUX and FF cells and grants the memory to one requester at a time, round-robin.
- Each grant runs a read-modify-write increment of that cell's counter.
- Also clears all counters after reset and streams every counter out on request.

---
 rtl/pwr_cntr_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_pwr_cntr_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwr_cntr_ctrl.sv
// Round-robin sequencer for the shared power-counter memory: clears counters after
// reset, runs read-modify-write increments per cell event, and streams counters on dump.
// Build option: PWR_CNTR_CLR_ON_DUMP_EN makes each dump read-and-clear.

// state    | meaning
// ---------+-----------------------------------------------------------
// INIT     | write zero to counter idx, idx 0..NCNT-1
// IDLE     | arbitrate: dump first, else round-robin over pending events
// RD       | read counter g
// WR       | write back counter g + 1 (saturating), retire pending[g]
// DUMP_RD  | read counter k
// DUMP_OUT | present counter k on the dump port
module pwr_cntr_ctrl #(
    parameter int NCNT = 5,
    parameter int AW   = 3,
    parameter int DW   = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [NCNT-1:0] REQ,
    output logic [AW-1:0]   MEM_ADDR,
    output logic            MEM_LE,
    output logic [DW-1:0]   MEM_WDATA,
    input  logic [DW-1:0]   MEM_RDATA,
    input  logic            DUMP_REQ,
    output logic            DUMP_VALID,
    output logic [AW-1:0]   DUMP_ADDR,
    output logic [DW-1:0]   DUMP_DATA,
    output logic            BUSY,
    output logic [NCNT-1:0] OVF
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD,
        S_WR,
        S_DUMP_RD,
        S_DUMP_OUT
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   idx, idx_nxt;
    logic [AW-1:0]   g, g_nxt;
    logic [AW-1:0]   rr_ptr, rr_nxt;
    logic [NCNT-1:0] pending, pending_nxt;
    logic [NCNT-1:0] ovf, ovf_nxt;
    logic            dump_pend, dump_pend_nxt;
    logic            dump_clr;

    logic [NCNT-1:0] clr_vec;
    logic [NCNT-1:0] req_eff;
    logic [AW:0]     cand;
    logic            grant_found;
    logic [AW-1:0]   grant_idx;

    logic            mem_le;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            dump_valid;
    logic [AW-1:0]   dump_addr;
    logic [DW-1:0]   dump_data;
    logic            busy;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_INIT;
            idx       <= '0;
            g         <= '0;
            rr_ptr    <= AW'(NCNT - 1);
            pending   <= '0;
            ovf       <= '0;
            dump_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            g         <= g_nxt;
            rr_ptr    <= rr_nxt;
            pending   <= pending_nxt;
            ovf       <= ovf_nxt;
            dump_pend <= dump_pend_nxt;
        end
    end

    // Event capture runs in every state; a retiring bit may be re-armed without loss.
    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < NCNT; i++) begin
            clr_vec[i] = (state == S_WR) && (g == AW'(i));
        end
        pending_nxt   = (pending & ~clr_vec) | REQ;
        ovf_nxt       = ovf | (REQ & pending & ~clr_vec);
        dump_pend_nxt = (dump_pend & ~dump_clr) | DUMP_REQ;
    end

    // Same-cycle events are visible to IDLE so an idle controller writes on the 3rd edge.
    always_comb begin
        req_eff     = pending | REQ;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int o = 1; o <= NCNT; o++) begin
            cand = {1'b0, rr_ptr} + (AW + 1)'(o);
            if (cand >= (AW + 1)'(NCNT)) begin
                cand = cand - (AW + 1)'(NCNT);
            end
            if (!grant_found && req_eff[cand[AW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[AW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        g_nxt      = g;
        rr_nxt     = rr_ptr;
        dump_clr   = 1'b0;
        mem_le     = 1'b1;
        mem_addr   = '0;
        mem_wdata  = '0;
        dump_valid = 1'b0;
        dump_addr  = '0;
        dump_data  = '0;
        busy       = 1'b1;

        case (state)
            S_INIT: begin
                mem_le   = 1'b0;
                mem_addr = idx;
                if (idx == AW'(NCNT - 1)) begin
                    idx_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    idx_nxt = idx + AW'(1);
                end
            end
            S_IDLE: begin
                busy = 1'b0;
                if (dump_pend) begin
                    dump_clr  = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = S_DUMP_RD;
                end else if (grant_found) begin
                    g_nxt     = grant_idx;
                    rr_nxt    = grant_idx;
                    state_nxt = S_RD;
                end
            end
            S_RD: begin
                mem_addr  = g;
                state_nxt = S_WR;
            end
            S_WR: begin
                mem_addr  = g;
                mem_le    = 1'b0;
                mem_wdata = (&MEM_RDATA) ? MEM_RDATA : MEM_RDATA + DW'(1);
                state_nxt = S_IDLE;
            end
            S_DUMP_RD: begin
                mem_addr  = idx;
                state_nxt = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                dump_valid = 1'b1;
                dump_addr  = idx;
                dump_data  = MEM_RDATA;
`ifdef PWR_CNTR_CLR_ON_DUMP_EN
                mem_le     = 1'b0;
                mem_addr   = idx;
`endif
                if (idx == AW'(NCNT - 1)) begin
                    idx_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    idx_nxt   = idx + AW'(1);
                    state_nxt = S_DUMP_RD;
                end
            end
            default: begin
                state_nxt = S_INIT;
                idx_nxt   = '0;
            end
        endcase

        // Outputs are forced to their quiet values for as long as reset is held.
        if (RESET) begin
            mem_le     = 1'b1;
            mem_addr   = '0;
            mem_wdata  = '0;
            dump_valid = 1'b0;
            dump_addr  = '0;
            dump_data  = '0;
            busy       = 1'b1;
        end
    end

    assign MEM_LE     = mem_le;
    assign MEM_ADDR   = mem_addr;
    assign MEM_WDATA  = mem_wdata;
    assign DUMP_VALID = dump_valid;
    assign DUMP_ADDR  = dump_addr;
    assign DUMP_DATA  = dump_data;
    assign BUSY       = busy;
    assign OVF        = RESET ? '0 : ovf;

endmodule

// File: tb/tb_pwr_cntr_ctrl.sv
// Directed self-checking bench for pwr_cntr_ctrl with a behavioural memory
// (registered read, write on MEM_LE=0) and a backdoor preload of counter 0.
module tb_pwr_cntr_ctrl;
    localparam int NCNT = 5;
    localparam int AW   = 3;
    localparam int DW   = 32;

    logic            CLK = 1'b0;
    logic            RESET;
    logic [NCNT-1:0] REQ;
    logic [AW-1:0]   MEM_ADDR;
    logic            MEM_LE;
    logic [DW-1:0]   MEM_WDATA;
    logic [DW-1:0]   MEM_RDATA;
    logic            DUMP_REQ;
    logic            DUMP_VALID;
    logic [AW-1:0]   DUMP_ADDR;
    logic [DW-1:0]   DUMP_DATA;
    logic            BUSY;
    logic [NCNT-1:0] OVF;

    always #5 CLK = ~CLK;

    pwr_cntr_ctrl #(.NCNT(NCNT), .AW(AW), .DW(DW)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .REQ        (REQ),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_LE     (MEM_LE),
        .MEM_WDATA  (MEM_WDATA),
        .MEM_RDATA  (MEM_RDATA),
        .DUMP_REQ   (DUMP_REQ),
        .DUMP_VALID (DUMP_VALID),
        .DUMP_ADDR  (DUMP_ADDR),
        .DUMP_DATA  (DUMP_DATA),
        .BUSY       (BUSY),
        .OVF        (OVF)
    );

    logic [DW-1:0] mem [0:7];
    logic          bd_en;
    logic [DW-1:0] bd_data;

    always @(posedge CLK) begin
        MEM_RDATA <= mem[MEM_ADDR];
        if (!MEM_LE) mem[MEM_ADDR] <= MEM_WDATA;
        if (bd_en) mem[0] <= bd_data;
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            c;
    } xact_t;

    xact_t wq[$];
    xact_t dq[$];

    always @(negedge CLK) begin
        if (!RESET && !MEM_LE) wq.push_back('{MEM_ADDR, MEM_WDATA, cyc});
        if (DUMP_VALID) dq.push_back('{DUMP_ADDR, DUMP_DATA, cyc});
    end

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_cnt [0:NCNT-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic init_seq(input string tag);
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        #1;
        for (int i = 0; i < NCNT; i++) begin
            chk($sformatf("%s_init_le_%0d", tag, i), 64'(MEM_LE), 64'(0));
            chk($sformatf("%s_init_addr_%0d", tag, i), 64'(MEM_ADDR), 64'(i));
            chk($sformatf("%s_init_wdata_%0d", tag, i), 64'(MEM_WDATA), 64'(0));
            chk($sformatf("%s_init_busy_%0d", tag, i), 64'(BUSY), 64'(1));
            tick();
        end
        chk($sformatf("%s_init_done_busy", tag), 64'(BUSY), 64'(0));
        chk($sformatf("%s_init_done_le", tag), 64'(MEM_LE), 64'(1));
    endtask

    task automatic run_dump(input string tag, input bit pulse);
        int base;
        int n;
        base = dq.size();
        if (pulse) begin
            DUMP_REQ = 1'b1;
            tick();
            DUMP_REQ = 1'b0;
        end
        n = 0;
        while (dq.size() < base + NCNT && n < 60) begin
            tick();
            n++;
        end
        chk($sformatf("%s_dump_count", tag), 64'(dq.size() - base), 64'(NCNT));
        for (int i = 0; i < NCNT; i++) begin
            if (base + i < dq.size()) begin
                chk($sformatf("%s_dump_addr_%0d", tag, i), 64'(dq[base+i].a), 64'(i));
                chk($sformatf("%s_dump_data_%0d", tag, i), 64'(dq[base+i].d), 64'(exp_cnt[i]));
            end
        end
        n = 0;
        while (BUSY && n < 10) begin
            tick();
            n++;
        end
        chk($sformatf("%s_dump_idle", tag), 64'(BUSY), 64'(0));
    endtask

    initial begin
        int base;
        RESET    = 1'b1;
        REQ      = '0;
        DUMP_REQ = 1'b0;
        bd_en    = 1'b0;
        bd_data  = '0;

        // Reset values held while RESET=1.
        tick();
        tick();
        chk("rst_le", 64'(MEM_LE), 64'(1));
        chk("rst_addr", 64'(MEM_ADDR), 64'(0));
        chk("rst_wdata", 64'(MEM_WDATA), 64'(0));
        chk("rst_busy", 64'(BUSY), 64'(1));
        chk("rst_ovf", 64'(OVF), 64'(0));
        chk("rst_dvalid", 64'(DUMP_VALID), 64'(0));
        chk("rst_daddr", 64'(DUMP_ADDR), 64'(0));
        chk("rst_ddata", 64'(DUMP_DATA), 64'(0));

        // Clear sequence, then an all-zero dump.
        init_seq("s1");
        for (int i = 0; i < NCNT; i++) exp_cnt[i] = '0;
        run_dump("s1", 1'b1);

        // Single event on cell 2.
        REQ = 5'b00100;
        tick();
        REQ = '0;
        chk("s2_rd_le", 64'(MEM_LE), 64'(1));
        chk("s2_rd_addr", 64'(MEM_ADDR), 64'(2));
        chk("s2_rd_busy", 64'(BUSY), 64'(1));
        tick();
        chk("s2_wr_le", 64'(MEM_LE), 64'(0));
        chk("s2_wr_addr", 64'(MEM_ADDR), 64'(2));
        chk("s2_wr_data", 64'(MEM_WDATA), 64'(1));
        tick();
        chk("s2_idle", 64'(BUSY), 64'(0));
        exp_cnt[2] = 32'd1;
        run_dump("s2", 1'b1);

        // All cells at once: round-robin from cell 0, three cycles apart.
        init_seq("s3");
        base = wq.size();
        REQ = 5'b11111;
        tick();
        REQ = '0;
        for (int i = 0; i < 16; i++) tick();
        chk("s3_wr_count", 64'(wq.size() - base), 64'(NCNT));
        for (int i = 0; i < NCNT; i++) begin
            if (base + i < wq.size()) begin
                chk($sformatf("s3_wr_addr_%0d", i), 64'(wq[base+i].a), 64'(i));
                chk($sformatf("s3_wr_data_%0d", i), 64'(wq[base+i].d), 64'(1));
                if (i > 0) chk($sformatf("s3_wr_gap_%0d", i),
                               64'(wq[base+i].c - wq[base+i-1].c), 64'(3));
            end
        end
        chk("s3_ovf", 64'(OVF), 64'(0));
        for (int i = 0; i < NCNT; i++) exp_cnt[i] = 32'd1;
        run_dump("s3", 1'b1);

        // Overflow on cell 1 during RMW of cell 3; cell 3 re-armed as it retires.
        init_seq("s4");
        base = wq.size();
        REQ = 5'b01000;
        tick();
        REQ = 5'b00010;
        chk("s4_rd_addr", 64'(MEM_ADDR), 64'(3));
        tick();
        REQ = 5'b01010;
        chk("s4_ovf_before", 64'(OVF), 64'(0));
        tick();
        REQ = '0;
        chk("s4_ovf_set", 64'(OVF), 64'(5'b00010));
        for (int i = 0; i < 12; i++) tick();
        chk("s4_ovf_sticky", 64'(OVF), 64'(5'b00010));
        chk("s4_wr_count", 64'(wq.size() - base), 64'(3));
        if (base + 2 < wq.size()) begin
            chk("s4_wr0", {29'd0, wq[base].a, wq[base].d}, {29'd0, 3'd3, 32'd1});
            chk("s4_wr1", {29'd0, wq[base+1].a, wq[base+1].d}, {29'd0, 3'd1, 32'd1});
            chk("s4_wr2", {29'd0, wq[base+2].a, wq[base+2].d}, {29'd0, 3'd3, 32'd2});
        end
        for (int i = 0; i < NCNT; i++) exp_cnt[i] = '0;
        exp_cnt[1] = 32'd1;
        exp_cnt[3] = 32'd2;
        run_dump("s4", 1'b1);

        // Saturation of counter 0.
        init_seq("s5");
        bd_en   = 1'b1;
        bd_data = 32'hFFFF_FFFF;
        tick();
        bd_en = 1'b0;
        REQ = 5'b00001;
        tick();
        REQ = '0;
        tick();
        chk("s5_wr_le", 64'(MEM_LE), 64'(0));
        chk("s5_wr_addr", 64'(MEM_ADDR), 64'(0));
        chk("s5_wr_data", 64'(MEM_WDATA), 64'(32'hFFFF_FFFF));
        tick();

        // Dump request during RD of cell 4 waits for the write-back.
        init_seq("s6");
        REQ = 5'b10000;
        tick();
        REQ = '0;
        DUMP_REQ = 1'b1;
        chk("s6_rd_addr", 64'(MEM_ADDR), 64'(4));
        chk("s6_rd_le", 64'(MEM_LE), 64'(1));
        tick();
        DUMP_REQ = 1'b0;
        chk("s6_wr_le", 64'(MEM_LE), 64'(0));
        chk("s6_wr_addr", 64'(MEM_ADDR), 64'(4));
        chk("s6_wr_data", 64'(MEM_WDATA), 64'(1));
        for (int i = 0; i < NCNT; i++) exp_cnt[i] = '0;
        exp_cnt[4] = 32'd1;
        run_dump("s6a", 1'b0);
`ifdef PWR_CNTR_CLR_ON_DUMP_EN
        exp_cnt[4] = '0;
`endif
        run_dump("s6b", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
